// File: rtl/bram_row_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_row_reader_if: start/abort control, BRAM port-B and FIFO push    |
// | signals for the row reader.  Rev 1.0                                  |
// +----------------------------------------------------------------------+
interface bram_row_reader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [63:0]       doutb;
  logic              fifo_push;
  logic [63:0]       fifo_data;
  logic [3:0]        fifo_count;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, base_addr, word_count, doutb, fifo_count,
    output enb, addrb, fifo_push, fifo_data, busy, done
  );

  modport slave (
    output start, abort, base_addr, word_count, doutb, fifo_count,
    input  enb, addrb, fifo_push, fifo_data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/bram_row_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bram_row_reader: reads a run of 64-bit BRAM words into the window     |
// | FIFO, one outstanding read at a time.  Rev 1.0                        |
// +----------------------------------------------------------------------+
module bram_row_reader #(
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 9,
  parameter int FIFO_ROOM = 7
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  bram_row_reader_if.master bus
);

  localparam logic [3:0] c_fifo_room = 4'(FIFO_ROOM);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remaining;

  logic w_room;
  logic w_enb;
  logic w_push;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.word_count != '0) begin
              r_addr      <= bus.base_addr;
              r_remaining <= bus.word_count;
              r_state     <= S_ISSUE;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.abort)  r_state <= S_IDLE;
          else if (w_room) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            r_addr      <= r_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            r_state     <= (r_remaining == CNT_W'(1)) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Room checked at issue still holds at push: only one read is ever in flight.
  assign w_room = (bus.fifo_count <= c_fifo_room);
  assign w_enb  = reset_n && (r_state == S_ISSUE) && w_room && !bus.abort;
  assign w_push = reset_n && (r_state == S_WAIT) && !bus.abort;

  assign bus.enb       = w_enb;
  assign bus.addrb     = w_enb ? r_addr : '0;
  assign bus.fifo_push = w_push;
  assign bus.fifo_data = w_push ? bus.doutb : 64'd0;
  assign bus.busy      = reset_n && (r_state != S_IDLE);
  assign bus.done      = reset_n && (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bram_row_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bram_row_reader: table-driven cycle vectors plus abort/reset runs. |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_bram_row_reader;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bram_row_reader_if #(.ADDR_W(8), .CNT_W(9)) bus ();

  bram_row_reader #(.ADDR_W(8), .CNT_W(9), .FIFO_ROOM(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [63:0] data_of(input logic [7:0] a);
    logic [7:0] a1;
    a1 = a + 8'd1;
    return {a, 8'h5A, ~a, 8'hC3, a1, 8'h00, a, 8'hE7};
  endfunction

  // One-cycle-latency BRAM model
  always @(posedge clk)
    if (bus.enb) bus.doutb <= data_of(bus.addrb);

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  base;
    logic [8:0]  cnt;
    logic [3:0]  fc;
    logic        e_enb;
    logic [7:0]  e_addr;
    logic        e_push;
    logic [63:0] e_data;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_step = 0;

  function automatic vec_t mk(input logic rst_n, start, abort, input logic [7:0] base,
                              input logic [8:0] cnt, input logic [3:0] fc,
                              input logic e_enb, input logic [7:0] e_addr,
                              input logic e_push, input logic [7:0] d_addr,
                              input logic e_busy, e_done);
    vec_t v;
    v.rst_n = rst_n; v.start = start; v.abort = abort;
    v.base = base; v.cnt = cnt; v.fc = fc;
    v.e_enb = e_enb; v.e_addr = e_addr; v.e_push = e_push;
    v.e_data = e_push ? data_of(d_addr) : 64'd0;
    v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL step %0d %s: got %h expected %h", n_step, name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset_n         = v.rst_n;
    bus.start       = v.start;
    bus.abort       = v.abort;
    bus.base_addr   = v.base;
    bus.word_count  = v.cnt;
    bus.fifo_count  = v.fc;
    #1;
    chk("enb",       64'(bus.enb),       64'(v.e_enb));
    chk("addrb",     64'(bus.addrb),     64'(v.e_addr));
    chk("fifo_push", 64'(bus.fifo_push), 64'(v.e_push));
    chk("fifo_data", bus.fifo_data,      v.e_data);
    chk("busy",      64'(bus.busy),      64'(v.e_busy));
    chk("done",      64'(bus.done),      64'(v.e_done));
    n_step++;
  endtask

  task automatic step(input logic rst_n, start, abort, input logic [7:0] base,
                      input logic [8:0] cnt, input logic [3:0] fc,
                      input logic e_enb, input logic [7:0] e_addr,
                      input logic e_push, input logic [7:0] d_addr,
                      input logic e_busy, e_done);
    apply(mk(rst_n, start, abort, base, cnt, fc, e_enb, e_addr, e_push, d_addr, e_busy, e_done));
  endtask

  task automatic add(input logic rst_n, start, abort, input logic [7:0] base,
                     input logic [8:0] cnt, input logic [3:0] fc,
                     input logic e_enb, input logic [7:0] e_addr,
                     input logic e_push, input logic [7:0] d_addr,
                     input logic e_busy, e_done);
    vecs.push_back(mk(rst_n, start, abort, base, cnt, fc, e_enb, e_addr, e_push, d_addr, e_busy, e_done));
  endtask

  initial begin
    // Run of 3 from 0x10; a start during ISSUE must be ignored (entries 0..8)
    add(1,1,0,8'h10,9'd3,4'd0, 0,8'h00, 0,8'h00, 0,0);
    add(1,0,0,8'h00,9'd0,4'd0, 1,8'h10, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 1,8'h10, 1,0);
    add(1,1,0,8'h50,9'd2,4'd0, 1,8'h11, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 1,8'h11, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 1,8'h12, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 1,8'h12, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 1,1);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    // FIFO stall at count 8, releases at the FIFO_ROOM boundary of 7
    add(1,1,0,8'h20,9'd1,4'd8, 0,8'h00, 0,8'h00, 0,0);
    for (int i = 0; i < 5; i++)
      add(1,0,0,8'h00,9'd0,4'd8, 0,8'h00, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd7, 1,8'h20, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd7, 0,8'h00, 1,8'h20, 1,0);
    add(1,0,0,8'h00,9'd0,4'd7, 0,8'h00, 0,8'h00, 1,1);
    add(1,0,0,8'h00,9'd0,4'd7, 0,8'h00, 0,8'h00, 0,0);
    // Address wrap 0xFE..0x01; a full FIFO during WAIT does not block the push
    add(1,1,0,8'hFE,9'd4,4'd0, 0,8'h00, 0,8'h00, 0,0);
    add(1,0,0,8'h00,9'd0,4'd0, 1,8'hFE, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd15,0,8'h00, 1,8'hFE, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 1,8'hFF, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd15,0,8'h00, 1,8'hFF, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 1,8'h00, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd15,0,8'h00, 1,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 1,8'h01, 0,8'h00, 1,0);
    add(1,0,0,8'h00,9'd0,4'd15,0,8'h00, 1,8'h01, 1,0);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 1,1);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    // Zero-length run goes straight to DONE; start during DONE is ignored
    add(1,1,0,8'h77,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    add(1,1,0,8'h33,9'd2,4'd0, 0,8'h00, 0,8'h00, 1,1);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    add(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);

    // Reset state, with start held high (must be ignored)
    step(0,1,0,8'h10,9'd3,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(0,1,0,8'h10,9'd3,4'd0, 0,8'h00, 0,8'h00, 0,0);

    foreach (vecs[i]) apply(vecs[i]);

    // Abort during the WAIT of word 2 of 5, abort in IDLE, then a clean run
    step(1,1,0,8'h30,9'd5,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(1,0,0,8'h00,9'd0,4'd0, 1,8'h30, 0,8'h00, 1,0);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 1,8'h30, 1,0);
    step(1,0,0,8'h00,9'd0,4'd0, 1,8'h31, 0,8'h00, 1,0);
    step(1,0,1,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 1,0);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(1,0,1,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(1,1,0,8'h40,9'd1,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(1,0,0,8'h00,9'd0,4'd0, 1,8'h40, 0,8'h00, 1,0);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 1,8'h40, 1,0);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 1,1);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    // Abort in ISSUE forces enb low even with room available
    step(1,1,0,8'h60,9'd2,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(1,0,1,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 1,0);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);

    // Reset pulse mid-run, then the first run replayed with identical timing
    step(1,1,0,8'h10,9'd3,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(1,0,0,8'h00,9'd0,4'd0, 1,8'h10, 0,8'h00, 1,0);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 1,8'h10, 1,0);
    step(0,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    step(1,0,0,8'h00,9'd0,4'd0, 0,8'h00, 0,8'h00, 0,0);
    for (int i = 0; i < 9; i++) apply(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_row_reader.md
Name: bram_row_reader

Overview:
- Upstream feeder for the 3-pixel sliding-window register FIFO in the input layer.
- On a start trigger, reads a run of consecutive 64-bit words (8 pixels each) from a block-RAM port B.
- Pushes each word into the downstream FIFO only when the FIFO reports room for it.
- Hides the 1-cycle BRAM read latency; signals completion with a one-cycle done pulse.

Parameters:
- ADDR_W, 8, BRAM address width (addrb width).
- CNT_W, 9, width of word_count; a run length of 1..2^ADDR_W words.
- FIFO_ROOM, 7, push allowed only while fifo_count <= FIFO_ROOM (the downstream FIFO holds 15 bytes, one word is 8).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  pulse: begin a run; sampled only in IDLE.
- abort  in  1  synchronous cancel of a run in progress.
- base_addr  in  ADDR_W  first BRAM word address, latched on start.
- word_count  in  CNT_W  number of words to read, latched on start.
- enb  out  1  BRAM port-B read enable.
- addrb  out  ADDR_W  BRAM port-B address.
- doutb  in  64  BRAM read data, valid the cycle after enb.
- fifo_push  out  1  push strobe to the downstream FIFO.
- fifo_data  out  64  push data; byte 0 (bits 7:0) is the leftmost pixel.
- fifo_count  in  4  downstream FIFO occupancy in bytes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Reset puts the block in IDLE with addr=0 and remaining=0.
- Reset values: enb=0, addrb=0, fifo_push=0, fifo_data=0 (when not pushing), busy=0, done=0.
- Reset asserted mid-run returns to IDLE immediately. There is no done pulse, and no push on the reset cycle.
- IDLE:
  - start=1 and word_count!=0: latch addr<=base_addr and remaining<=word_count, go to ISSUE.
  - start=1 and word_count==0: go to DONE.
  - start outside IDLE is ignored.
- ISSUE:
  - If fifo_count <= FIFO_ROOM: enb=1, addrb=addr, go to WAIT.
  - Otherwise enb=0 and the block stays in ISSUE. This is the stall; it may last any number of cycles.
  - enb is combinational from state and fifo_count.
- WAIT:
  - fifo_push=1 and fifo_data=doutb, passed through combinationally.
  - addr<=addr+1, wrapping from 2^ADDR_W-1 to 0. remaining<=remaining-1.
  - If remaining==1, go to DONE; else go to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in this cycle.
- Outstanding reads: at most one, so room checked at issue is still guaranteed at push. Downstream pops only lower the count, and no other push can intervene.
- Throughput: at most one word every 2 cycles, which is 4 bytes/cycle. That exceeds the 1 byte/cycle downstream pop rate.
- fifo_push and enb are never high in the same cycle.
- abort=1 in ISSUE or WAIT:
  - Next state is IDLE; enb=0 and fifo_push=0 are forced that cycle.
  - Data returned in WAIT is dropped; no done pulse.
  - abort has priority over all other transitions. abort in IDLE or DONE has no effect.
- Arithmetic: addr is ADDR_W bits, modulo 2^ADDR_W. remaining is CNT_W bits and never underflows, because exit happens when remaining==1.

Test Plan:
- base_addr=0x10, word_count=3, fifo_count held at 0 -> enb in cycles 1, 3, 5 with addrb 0x10, 0x11, 0x12. Pushes in cycles 2, 4, 6 carry doutb of each. done pulses in cycle 7; busy is 0 from cycle 8.
- fifo_count=8 for 5 cycles after start, then 7 -> no enb while count=8. First enb in the cycle count drops to 7, push in the next cycle.
- base_addr=0xFE, word_count=4 -> addrb sequence 0xFE, 0xFF, 0x00, 0x01 with 4 pushes, then done.
- word_count=0 with start -> no enb and no push; done one cycle after start, then IDLE.
- abort asserted during the WAIT of word 2 of 5 -> no push that cycle. Block returns to IDLE with no done. A new start then runs cleanly from its own base_addr.
- reset_n=0 for one cycle mid-run, then start re-issued -> all outputs 0 during reset. The new run matches the first scenario's timing.
